sensor_front_end: RTL and testbench

//   Conditions the raw stress-sensor inputs before they reach the stress-detection logic.
//   Per channel: 2-FF synchronizer, tick-based debouncer, and a single-cycle rising-edge pulse (feeds signalN).

---
 rtl/sensor_front_end_if.sv | 23 ++
 rtl/sensor_front_end.sv | 106 ++++++++++
 tb/tb_sensor_front_end.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sensor_front_end_if.sv
// Bus between the sensor front end and its environment.
// The environment drives the strobe, raw inputs and fault clear; the block returns the conditioned levels.
interface sensor_front_end_if #(
    parameter int NUM_CH = 3
);
    logic              tick;
    logic [NUM_CH-1:0] sensor_raw;
    logic              clear_fault;
    logic [NUM_CH-1:0] sensor_level;
    logic [NUM_CH-1:0] sensor_pulse;
    logic [NUM_CH-1:0] stuck_fault;
    logic              fault_any;

    modport master (
        output tick, sensor_raw, clear_fault,
        input  sensor_level, sensor_pulse, stuck_fault, fault_any
    );

    modport slave (
        input  tick, sensor_raw, clear_fault,
        output sensor_level, sensor_pulse, stuck_fault, fault_any
    );
endinterface

// File: rtl/sensor_front_end.sv
// Per-channel synchronizer, tick-based debouncer, rising-edge pulse and stuck-high detector
// for the raw stress-sensor inputs; all timing is counted in 1 kHz tick strobes.
module sensor_front_end #(
    parameter int NUM_CH         = 3,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int STUCK_TICKS    = 5000
) (
    input  logic                clk,
    input  logic                reset,
    sensor_front_end_if.slave   bus
);
    localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam int ST_W = $clog2(STUCK_TICKS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STUCK_TICKS);

    logic [NUM_CH-1:0] sync_meta_r;
    logic [NUM_CH-1:0] sync_r;
    logic [NUM_CH-1:0] level_r;
    logic [NUM_CH-1:0] level_d_r;
    logic [NUM_CH-1:0] pulse_r;
    logic [NUM_CH-1:0] fault_r;
    logic [DB_W-1:0]   db_cnt_r [NUM_CH];
    logic [ST_W-1:0]   st_cnt_r [NUM_CH];

    logic [NUM_CH-1:0] level_nxt_s;
    logic [NUM_CH-1:0] fault_nxt_s;
    logic [DB_W-1:0]   db_cnt_nxt_s [NUM_CH];
    logic [ST_W-1:0]   st_cnt_nxt_s [NUM_CH];

    // Debounce: level follows sync only after DEBOUNCE_TICKS consecutive disagreeing ticks.
    always_comb begin
        level_nxt_s = level_r;
        for (int i = 0; i < NUM_CH; i++) begin
            db_cnt_nxt_s[i] = db_cnt_r[i];
            if (bus.tick) begin
                if (sync_r[i] == level_r[i]) begin
                    db_cnt_nxt_s[i] = {DB_W{1'b0}};
                end else if (db_cnt_r[i] == DB_LAST) begin
                    level_nxt_s[i]  = sync_r[i];
                    db_cnt_nxt_s[i] = {DB_W{1'b0}};
                end else begin
                    db_cnt_nxt_s[i] = db_cnt_r[i] + DB_W'(1);
                end
            end else begin
                db_cnt_nxt_s[i] = db_cnt_r[i];
            end
        end
    end

    // Stuck-high detection; a clear or a falling level resets the count and drops the fault in the same update.
    always_comb begin
        fault_nxt_s = fault_r;
        for (int i = 0; i < NUM_CH; i++) begin
            st_cnt_nxt_s[i] = st_cnt_r[i];
            if (bus.clear_fault) begin
                st_cnt_nxt_s[i] = {ST_W{1'b0}};
                fault_nxt_s[i]  = 1'b0;
            end else if (!level_nxt_s[i]) begin
                st_cnt_nxt_s[i] = {ST_W{1'b0}};
                fault_nxt_s[i]  = 1'b0;
            end else begin
                fault_nxt_s[i] = fault_r[i] | (st_cnt_r[i] == ST_MAX);
                if (bus.tick && level_r[i] && (st_cnt_r[i] != ST_MAX)) begin
                    st_cnt_nxt_s[i] = st_cnt_r[i] + ST_W'(1);
                end else begin
                    st_cnt_nxt_s[i] = st_cnt_r[i];
                end
            end
        end
    end

    // State and output registers; reset aborts any pending debounce or stuck count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta_r <= {NUM_CH{1'b0}};
            sync_r      <= {NUM_CH{1'b0}};
            level_r     <= {NUM_CH{1'b0}};
            level_d_r   <= {NUM_CH{1'b0}};
            pulse_r     <= {NUM_CH{1'b0}};
            fault_r     <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
                st_cnt_r[i] <= {ST_W{1'b0}};
            end
        end else begin
            sync_meta_r <= bus.sensor_raw;
            sync_r      <= sync_meta_r;
            level_r     <= level_nxt_s;
            level_d_r   <= level_r;
            // Pulse is registered from the already-registered level, so it trails the level rise by one clk.
            pulse_r     <= level_r & ~level_d_r;
            fault_r     <= fault_nxt_s;
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt_r[i] <= db_cnt_nxt_s[i];
                st_cnt_r[i] <= st_cnt_nxt_s[i];
            end
        end
    end

    assign bus.sensor_level = level_r;
    assign bus.sensor_pulse = pulse_r;
    assign bus.stuck_fault  = fault_r;
    assign bus.fault_any    = |fault_r;

endmodule

// File: tb/tb_sensor_front_end.sv
// Self-checking bench for sensor_front_end: directed scenarios plus randomized inputs,
// compared every cycle against a tick-counting behavioural model.
module tb_sensor_front_end;
    localparam int NUM_CH = 3;
    localparam int DB     = 4;
    localparam int ST     = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sensor_front_end_if #(.NUM_CH(NUM_CH)) bus ();

    sensor_front_end #(
        .NUM_CH(NUM_CH), .DEBOUNCE_TICKS(DB), .STUCK_TICKS(ST)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model: raw history two clocks deep, run length of disagreeing ticks, ticks spent high
    bit m_raw_h1 [NUM_CH];
    bit m_raw_h2 [NUM_CH];
    bit m_lvl    [NUM_CH];
    bit m_lvl_d  [NUM_CH];
    bit m_pulse  [NUM_CH];
    bit m_fault  [NUM_CH];
    int m_run    [NUM_CH];
    int m_high   [NUM_CH];
    int pulse_seen [NUM_CH];
    int tphase = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_raw_h1[c] = 1'b0; m_raw_h2[c] = 1'b0; m_lvl[c] = 1'b0; m_lvl_d[c] = 1'b0;
            m_pulse[c] = 1'b0; m_fault[c] = 1'b0; m_run[c] = 0; m_high[c] = 0;
        end
    endtask

    // Advance the model over one clock edge using the inputs that were stable before it.
    task automatic model_clock();
        bit old_lvl, new_lvl;
        if (reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            old_lvl = m_lvl[c];
            new_lvl = old_lvl;
            if (bus.tick) begin
                if (m_raw_h2[c] != old_lvl) begin
                    m_run[c]++;
                    if (m_run[c] >= DB) begin
                        new_lvl  = !old_lvl;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_pulse[c] = old_lvl && !m_lvl_d[c];
            m_lvl_d[c] = old_lvl;
            if (bus.clear_fault || !new_lvl) begin
                m_fault[c] = 1'b0;
                m_high[c]  = 0;
            end else begin
                m_fault[c] = m_fault[c] || (m_high[c] >= ST);
                if (bus.tick && old_lvl) m_high[c]++;
            end
            m_lvl[c]    = new_lvl;
            m_raw_h2[c] = m_raw_h1[c];
            m_raw_h1[c] = bus.sensor_raw[c];
        end
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0] e_lvl, e_pls, e_flt;
        for (int c = 0; c < NUM_CH; c++) begin
            e_lvl[c] = m_lvl[c]; e_pls[c] = m_pulse[c]; e_flt[c] = m_fault[c];
            pulse_seen[c] += int'(bus.sensor_pulse[c]);
        end
        check_value("level", 32'(bus.sensor_level), 32'(e_lvl));
        check_value("pulse", 32'(bus.sensor_pulse), 32'(e_pls));
        check_value("stuck_fault", 32'(bus.stuck_fault), 32'(e_flt));
        check_value("fault_any", 32'(bus.fault_any), 32'(|e_flt));
    endtask

    // One clock: drive at negedge (already there), model at posedge, check at next negedge.
    task automatic cyc(input logic [NUM_CH-1:0] raw, input logic clr);
        bus.sensor_raw  = raw;
        bus.clear_fault = clr;
        bus.tick        = (tphase == 4);
        tphase          = (tphase + 1) % 5;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_ticks(input logic [NUM_CH-1:0] raw, input int n);
        for (int k = 0; k < 5 * n; k++) cyc(raw, 1'b0);
    endtask

    task automatic clear_pulse_counts();
        for (int c = 0; c < NUM_CH; c++) pulse_seen[c] = 0;
    endtask

    task automatic do_reset(input logic [NUM_CH-1:0] raw, input int ncyc);
        reset = 1'b1;
        #1;
        model_reset();
        check_value("reset_level", 32'(bus.sensor_level), 32'd0);
        check_value("reset_fault", 32'(bus.fault_any), 32'd0);
        for (int k = 0; k < ncyc; k++) cyc(raw, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [NUM_CH-1:0] rnd_raw;
        bus.sensor_raw = '0; bus.clear_fault = 1'b0; bus.tick = 1'b0;
        reset = 1'b1;
        model_reset();
        clear_pulse_counts();
        @(negedge clk);

        // reset held with all inputs high, then each channel pulses once after debounce
        do_reset(3'b111, 6);
        check_value("reset_pulse", 32'(bus.sensor_pulse), 32'd0);
        clear_pulse_counts();
        run_ticks(3'b111, 7);
        for (int c = 0; c < NUM_CH; c++) check_value("rst_release_pulses", 32'(pulse_seen[c]), 32'd1);
        check_value("rst_release_level", 32'(bus.sensor_level), 32'b111);

        run_ticks(3'b000, 7);
        check_value("fall_level", 32'(bus.sensor_level), 32'b000);
        check_value("fall_no_pulse", 32'(pulse_seen[0] + pulse_seen[1] + pulse_seen[2]), 32'd3);

        // bounce rejection on ch0
        clear_pulse_counts();
        run_ticks(3'b001, 3);
        run_ticks(3'b000, 1);
        run_ticks(3'b001, 3);
        check_value("bounce_level", 32'(bus.sensor_level[0]), 32'd0);
        check_value("bounce_pulse", 32'(pulse_seen[0]), 32'd0);
        run_ticks(3'b001, 4);
        check_value("hold_level", 32'(bus.sensor_level[0]), 32'd1);
        check_value("hold_pulse", 32'(pulse_seen[0]), 32'd1);

        // clean press and release on ch1
        clear_pulse_counts();
        run_ticks(3'b010, 6);
        run_ticks(3'b000, 6);
        check_value("press_pulse", 32'(pulse_seen[1]), 32'd1);
        check_value("release_level", 32'(bus.sensor_level[1]), 32'd0);

        // stuck detect on ch2, then release
        run_ticks(3'b100, 16);
        check_value("stuck_set", 32'(bus.stuck_fault), 32'b100);
        check_value("stuck_any", 32'(bus.fault_any), 32'd1);
        run_ticks(3'b000, 6);
        check_value("stuck_drop", 32'(bus.stuck_fault), 32'd0);

        // clear_fault on a tick cycle while ch2 stays high
        clear_pulse_counts();
        run_ticks(3'b100, 16);
        check_value("stuck_again", 32'(bus.stuck_fault[2]), 32'd1);
        while (tphase != 4) cyc(3'b100, 1'b0);
        cyc(3'b100, 1'b1);
        check_value("clear_now", 32'(bus.stuck_fault[2]), 32'd0);
        run_ticks(3'b100, 8);
        check_value("clear_hold", 32'(bus.stuck_fault[2]), 32'd0);
        run_ticks(3'b100, 4);
        check_value("refault", 32'(bus.stuck_fault[2]), 32'd1);
        cyc(3'b100, 1'b1);
        check_value("clear_offtick", 32'(bus.stuck_fault[2]), 32'd0);
        check_value("clear_no_pulse", 32'(pulse_seen[2]), 32'd1);
        run_ticks(3'b000, 6);

        // reset in the middle of a debounce
        run_ticks(3'b001, 2);
        do_reset(3'b001, 3);
        run_ticks(3'b001, 3);
        check_value("mid_rst_hold", 32'(bus.sensor_level[0]), 32'd0);
        run_ticks(3'b001, 2);
        check_value("mid_rst_rise", 32'(bus.sensor_level[0]), 32'd1);

        // randomized phase
        rnd_raw = 3'b000;
        for (int blk = 0; blk < 400; blk++) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(9) == 0) rnd_raw[c] = ~rnd_raw[c];
            for (int k = 0; k < 5; k++) begin
                if ($urandom_range(15) == 0) rnd_raw[$urandom_range(NUM_CH - 1)] ^= 1'b1;
                cyc(rnd_raw, $urandom_range(60) == 0);
            end
            if (blk == 200) do_reset(rnd_raw, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
